// File: rtl/instr_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding and fetch constants.
package instr_fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam logic [31:0] TEXT_BASE_DEF  = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;
    localparam int unsigned PC_STEP        = 4;

endpackage

// File: rtl/instr_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: bubble has priority over load; neither asserted means hold.
module instr_fetch_stage_if_id_reg
    import instr_fetch_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  bubble,
    input  logic [DATA_WIDTH-1:0] instr_d,
    input  logic [DATA_WIDTH-1:0] pc_d,
    output logic [DATA_WIDTH-1:0] instr_q,
    output logic [DATA_WIDTH-1:0] pc_q,
    output logic [DATA_WIDTH-1:0] pc_plus4_q,
    output logic                  valid_q
);

    localparam logic [DATA_WIDTH-1:0] STEP = DATA_WIDTH'(PC_STEP);
    localparam logic [DATA_WIDTH-1:0] NOP  = DATA_WIDTH'(NOP_INSTR);

    // Bubble keeps the PC fields; only instr and valid are squashed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q    <= '0;
            pc_q       <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else if (bubble) begin
            instr_q    <= NOP;
            valid_q    <= 1'b0;
        end else if (load) begin
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_d + STEP;
            valid_q    <= 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction-fetch stage: PC, fetch FSM, range halt and redirect handling.
// Optional misaligned-redirect fault enabled by defining FETCH_ALIGN_CHECK_EN.
module instr_fetch_stage
    import instr_fetch_stage_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = DATA_WIDTH_DEF,
    parameter logic [DATA_WIDTH-1:0] TEXT_BASE  = DATA_WIDTH'(TEXT_BASE_DEF),
    parameter int unsigned           IMEM_WORDS = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rd,
    output logic [DATA_WIDTH-1:0] if_id_instr,
    output logic [DATA_WIDTH-1:0] if_id_pc,
    output logic [DATA_WIDTH-1:0] if_id_pc_plus4,
    output logic                  if_id_valid,
    output logic                  halted,
    output logic                  fetch_fault
);

    localparam logic [DATA_WIDTH-1:0] STEP       = DATA_WIDTH'(PC_STEP);
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(PC_STEP - 1);
    localparam logic [DATA_WIDTH-1:0] TEXT_LAST  =
        TEXT_BASE + DATA_WIDTH'(PC_STEP * IMEM_WORDS - PC_STEP);

    fetch_state_e          state_q;
    fetch_state_e          state_d;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] pc_d;
    logic [DATA_WIDTH-1:0] pc_next_seq;
    logic [DATA_WIDTH-1:0] redir_tgt;
    logic                  pc_in_range;
    logic                  tgt_in_range;
    logic                  redir_misaligned;
    logic                  ifid_load;
    logic                  ifid_bubble;
    logic                  halted_d;
    logic                  fault_d;
    logic                  fault_q;

    assign imem_addr    = pc_q;
    assign pc_next_seq  = pc_q + STEP;
    assign redir_tgt    = redirect_pc & ALIGN_MASK;
    assign pc_in_range  = (pc_q >= TEXT_BASE) && (pc_q <= TEXT_LAST);
    assign tgt_in_range = (redir_tgt >= TEXT_BASE) && (redir_tgt <= TEXT_LAST);
    assign fetch_fault  = fault_q;

`ifdef FETCH_ALIGN_CHECK_EN
    assign redir_misaligned = |redirect_pc[1:0];
`else
    assign redir_misaligned = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (redirect_valid) begin
                    if (redir_misaligned) state_d = ST_HALT;
                end else if (!pc_in_range) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (redirect_valid && !redir_misaligned && tgt_in_range) state_d = ST_RUN;
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // Datapath controls: redirect beats range check, which beats flush, then stall
    always_comb begin
        pc_d        = pc_q;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        halted_d    = halted;
        fault_d     = fault_q;
        case (state_q)
            ST_RUN: begin
                if (redirect_valid) begin
                    ifid_bubble = 1'b1;
                    if (redir_misaligned) begin
                        fault_d  = 1'b1;
                        halted_d = 1'b1;
                    end else begin
                        pc_d = redir_tgt;
                    end
                end else if (!pc_in_range) begin
                    ifid_bubble = 1'b1;
                    halted_d    = 1'b1;
                end else if (flush) begin
                    ifid_bubble = 1'b1;
                    if (!stall) pc_d = pc_next_seq;
                end else if (!stall) begin
                    ifid_load = 1'b1;
                    pc_d      = pc_next_seq;
                end
            end
            ST_HALT: begin
                if (redirect_valid) begin
                    if (redir_misaligned) begin
                        fault_d = 1'b1;
                    end else if (tgt_in_range) begin
                        pc_d     = redir_tgt;
                        halted_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    // PC and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= TEXT_BASE;
            halted  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            halted  <= halted_d;
            fault_q <= fault_d;
        end
    end

    instr_fetch_stage_if_id_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_if_id_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (ifid_load),
        .bubble     (ifid_bubble),
        .instr_d    (imem_rd),
        .pc_d       (pc_q),
        .instr_q    (if_id_instr),
        .pc_q       (if_id_pc),
        .pc_plus4_q (if_id_pc_plus4),
        .valid_q    (if_id_valid)
    );

endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
Instruction-fetch stage directly upstream of the instruction memory. Owns the program counter, drives the byte address into the instruction ROM (text segment based at 0x0040_0000), and captures the returned word into the IF/ID pipeline register. Handles stall, flush, redirect (branch/jump) and an out-of-range halt, and feeds the decode stage.

Parameters:
DATA_WIDTH, 32, instruction and address width in bits
TEXT_BASE, 32'h0040_0000, reset PC and first valid instruction address
IMEM_WORDS, 1024, number of instruction words; valid range is TEXT_BASE to TEXT_BASE+4*IMEM_WORDS-4

Ports:
clk  in  1  single clock, all state on posedge
rst_n  in  1  asynchronous active-low reset
stall  in  1  hazard unit: hold PC and IF/ID contents
flush  in  1  squash the IF/ID entry (insert bubble)
redirect_valid  in  1  branch/jump taken; load redirect_pc
redirect_pc  in  DATA_WIDTH  target byte address
imem_addr  out  DATA_WIDTH  byte address to instruction memory (= pc)
imem_rd  in  DATA_WIDTH  combinational read data from instruction memory
if_id_instr  out  DATA_WIDTH  registered instruction to decode
if_id_pc  out  DATA_WIDTH  registered PC of if_id_instr
if_id_pc_plus4  out  DATA_WIDTH  registered if_id_pc+4
if_id_valid  out  1  IF/ID entry holds a real instruction
halted  out  1  fetch stopped on out-of-range PC
fetch_fault  out  1  misaligned redirect seen (FETCH_ALIGN_CHECK_EN only; else tied 0)

Behaviour:
- Reset (async, rst_n=0): pc=TEXT_BASE, state=BOOT, if_id_instr=0, if_id_pc=0, if_id_pc_plus4=0, if_id_valid=0, halted=0, fetch_fault=0. Reset mid-operation discards everything immediately.
- imem_addr = pc combinationally; imem_rd is valid the same cycle (zero-latency ROM). Fetch-to-decode latency: 1 clock.
- FSM states: BOOT, RUN, HALT.
  - BOOT: one cycle after reset release; no capture, if_id_valid stays 0; -> RUN.
  - RUN: per posedge, priority order: (1) redirect_valid: pc<=redirect_pc, IF/ID loaded with bubble (valid=0, instr=0) regardless of stall; (2) flush alone: IF/ID bubble, pc<=pc+4 unless stall (stall holds pc); (3) stall: pc and IF/ID hold; (4) otherwise pc<=pc+4, IF/ID<={imem_rd, pc, pc+4}, valid=1.
  - Range check each RUN cycle before capture: if pc<TEXT_BASE or pc>TEXT_BASE+4*IMEM_WORDS-4 then no capture, IF/ID bubble, pc holds, halted<=1, -> HALT. A redirect in the same cycle wins (PC loaded, no halt).
  - HALT: pc and IF/ID frozen as bubble; only redirect_valid with in-range target returns to RUN (halted<=0). Exit only via reset otherwise.
- Bubble instruction encoding is 32'h0000_0000 (sll $0,$0,0 = NOP).
- pc+4 wraps modulo 2^DATA_WIDTH; wrap lands out-of-range and halts.
- redirect_pc low two bits ignored for addressing (forced 00) when feature disabled.

Optional Feature:
FETCH_ALIGN_CHECK_EN: when defined, redirect_valid with redirect_pc[1:0]!=0 sets sticky fetch_fault<=1, pc holds, IF/ID bubble, -> HALT (halted=1); cleared only by reset. When undefined, fetch_fault is constant 0 and redirect_pc[1:0] are forced to 00.

Decomposition:
- Shared package: fetch FSM state encoding (BOOT/RUN/HALT), NOP_INSTR=32'h0, TEXT_BASE default, PC_STEP=4.
- One sub-module natural: if_id_reg (instr/pc/pc_plus4/valid register with load, hold, bubble controls); PC logic and FSM stay in top.

Test Plan:
- Reset release, imem returns 0x2008_0005 at 0x0040_0000 -> cycle 1 BOOT valid=0; cycle 2 if_id_instr=0x2008_0005, if_id_pc=0x0040_0000, pc_plus4=0x0040_0004, valid=1.
- stall high 3 cycles at pc=0x0040_0008 -> imem_addr and IF/ID unchanged 3 cycles; resumes at 0x0040_000C.
- redirect_valid=1, redirect_pc=0x0040_0020 together with stall=1 -> next cycle imem_addr=0x0040_0020, if_id_valid=0; following cycle captures instruction at 0x0040_0020.
- IMEM_WORDS=4, run sequentially -> after pc=0x0040_000C captured, pc=0x0040_0010 sets halted=1, valid=0; redirect to 0x0040_0000 -> halted=0, fetch resumes.
- Assert rst_n=0 mid-run with valid=1 -> outputs zero and pc=0x0040_0000 immediately (asynchronous, before next edge).
- FETCH_ALIGN_CHECK_EN defined, redirect_pc=0x0040_0006 -> fetch_fault=1, halted=1, valid=0; undefined -> fetch from 0x0040_0004, fetch_fault=0.
